// File: rtl/gt_link_ctrl.sv
// Per-lane GT link bring-up/retrain sequencer: TX/RX reset sequencing, alignment qualification, retry and fault latch.
// Optional GT_LINK_CTRL_STATS_EN adds o_linkdown_cnt (saturating count of link-up losses).
module gt_link_ctrl #(
  parameter int unsigned P_RST_CYCLE     = 10,
  parameter int unsigned P_TX_TIMEOUT    = 65535,
  parameter int unsigned P_ALIGN_TIMEOUT = 65535,
  parameter int unsigned P_STABLE_CYCLE  = 1024,
  parameter int unsigned P_MAX_RETRY     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_gt_tx_done,
  input  logic       i_rx_ByteAlign,
  input  logic       i_retrain,
  output logic       o_tx_rst,
  output logic       o_rx_rst,
  output logic       o_link_up,
  output logic       o_link_fault,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
`ifdef GT_LINK_CTRL_STATS_EN
  ,
  output logic [15:0] o_linkdown_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_RST        = 3'd0,
    ST_WAIT_TX    = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_STABLE     = 3'd3,
    ST_UP         = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(P_RST_CYCLE - 1);
  localparam logic [15:0] TX_LAST     = 16'(P_TX_TIMEOUT - 1);
  localparam logic [15:0] ALIGN_LAST  = 16'(P_ALIGN_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(P_STABLE_CYCLE - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(P_MAX_RETRY);

  state_t      state_d, state_q;
  logic        tx_rst_d, tx_rst_q;
  logic        rx_rst_d, rx_rst_q;
  logic        link_up_d, link_up_q;
  logic        fault_d, fault_q;
  logic [3:0]  retry_d, retry_q;
  logic [15:0] timer_d, timer_q;
  logic [1:0]  tx_sync_d, tx_sync_q;
  logic [1:0]  align_sync_d, align_sync_q;
  logic        tx_done_s, align_s;
  logic        fail;
  logic [3:0]  retry_inc;

  assign tx_done_s = tx_sync_q[1];
  assign align_s   = align_sync_q[1];
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    tx_sync_d    = {tx_sync_q[0], i_gt_tx_done};
    align_sync_d = {align_sync_q[0], i_rx_ByteAlign};
  end

  always_comb begin
    state_d   = state_q;
    tx_rst_d  = tx_rst_q;
    rx_rst_d  = rx_rst_q;
    link_up_d = 1'b0;
    fault_d   = fault_q;
    retry_d   = retry_q;
    fail      = 1'b0;

    case (state_q)
      ST_RST: begin
        tx_rst_d = 1'b1;
        rx_rst_d = 1'b1;
        if (timer_q == RST_LAST) begin
          state_d  = ST_WAIT_TX;
          tx_rst_d = 1'b0;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done_s) begin
          state_d  = ST_WAIT_ALIGN;
          rx_rst_d = 1'b0;
        end else if (timer_q == TX_LAST) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_ALIGN: begin
        if (align_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == ALIGN_LAST) begin
          fail = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!align_s || !tx_done_s) begin
          fail = 1'b1;
        end else if (timer_q == STABLE_LAST) begin
          state_d   = ST_UP;
          retry_d   = '0;
          link_up_d = 1'b1;
        end
      end
      ST_UP: begin
        if (!align_s || !tx_done_s) begin
          fail = 1'b1;
        end else begin
          link_up_d = 1'b1;
        end
      end
      ST_FAULT: begin
        tx_rst_d = 1'b1;
        rx_rst_d = 1'b1;
      end
      default: begin
        state_d  = ST_RST;
        tx_rst_d = 1'b1;
        rx_rst_d = 1'b1;
      end
    endcase

    if (fail) begin
      retry_d   = retry_inc;
      tx_rst_d  = 1'b1;
      rx_rst_d  = 1'b1;
      link_up_d = 1'b0;
      if (retry_inc == RETRY_MAX) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = ST_RST;
      end
    end

    // Retrain overrides any failure detected in the same cycle.
    if (i_retrain && (state_q != ST_RST)) begin
      state_d   = ST_RST;
      retry_d   = '0;
      fault_d   = 1'b0;
      tx_rst_d  = 1'b1;
      rx_rst_d  = 1'b1;
      link_up_d = 1'b0;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_RST;
      tx_rst_q     <= 1'b1;
      rx_rst_q     <= 1'b1;
      link_up_q    <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= '0;
      timer_q      <= '0;
      tx_sync_q    <= '0;
      align_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_rst_q     <= tx_rst_d;
      rx_rst_q     <= rx_rst_d;
      link_up_q    <= link_up_d;
      fault_q      <= fault_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      tx_sync_q    <= tx_sync_d;
      align_sync_q <= align_sync_d;
    end
  end

  assign o_tx_rst     = tx_rst_q;
  assign o_rx_rst     = rx_rst_q;
  assign o_link_up    = link_up_q;
  assign o_link_fault = fault_q;
  assign o_retry_cnt  = retry_q;
  assign o_state      = state_q;

`ifdef GT_LINK_CTRL_STATS_EN
  logic [15:0] linkdown_cnt_d, linkdown_cnt_q;

  always_comb begin
    linkdown_cnt_d = linkdown_cnt_q;
    if ((state_q == ST_UP) && fail && !i_retrain && (linkdown_cnt_q != '1)) begin
      linkdown_cnt_d = linkdown_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      linkdown_cnt_q <= '0;
    end else begin
      linkdown_cnt_q <= linkdown_cnt_d;
    end
  end

  assign o_linkdown_cnt = linkdown_cnt_q;
`endif

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Scoreboard bench for gt_link_ctrl: each output-bundle change is matched against a queued expectation (value and cycle).
module tb_gt_link_ctrl;

  typedef struct {
    logic [10:0] vec;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_done;
  logic        align;
  logic        retrain;
  logic        tx_rst, rx_rst, link_up, link_fault;
  logic [3:0]  retry_cnt;
  logic [2:0]  state;
`ifdef GT_LINK_CTRL_STATS_EN
  logic [15:0] linkdown_cnt;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gt_link_ctrl #(
    .P_RST_CYCLE(10),
    .P_TX_TIMEOUT(200),
    .P_ALIGN_TIMEOUT(100),
    .P_STABLE_CYCLE(1024),
    .P_MAX_RETRY(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_gt_tx_done(tx_done),
    .i_rx_ByteAlign(align),
    .i_retrain(retrain),
    .o_tx_rst(tx_rst),
    .o_rx_rst(rx_rst),
    .o_link_up(link_up),
    .o_link_fault(link_fault),
    .o_retry_cnt(retry_cnt),
    .o_state(state)
`ifdef GT_LINK_CTRL_STATS_EN
    ,
    .o_linkdown_cnt(linkdown_cnt)
`endif
  );

  logic [10:0] outv;
  assign outv = {state, tx_rst, rx_rst, link_up, link_fault, retry_cnt};

  function automatic logic [10:0] mk(input int st, input bit tx, input bit rx,
                                     input bit up, input bit f, input int r);
    logic [2:0] s3;
    logic [3:0] r4;
    s3 = 3'(st);
    r4 = 4'(r);
    return {s3, tx, rx, up, f, r4};
  endfunction

  task automatic push(input int st, input bit tx, input bit rx, input bit up,
                      input bit f, input int r, input int at);
    exp_t e;
    e.vec = mk(st, tx, rx, up, f, r);
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every change of the output bundle consumes one expectation.
  initial begin
    logic [10:0] prev;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (outv !== prev) begin
        prev = outv;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b expected no change (cycle %0d)", outv, cyc);
        end else begin
          e = exp_q.pop_front();
          if (outv !== e.vec) begin
            errors++;
            $display("FAIL out_value: got %b expected %b (cycle %0d)", outv, e.vec, cyc);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL out_timing: vector %b seen at cycle %0d expected cycle %0d", outv, cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a, b, g, c, d, e, f;
    rst_n   = 1'b1;
    tx_done = 1'b0;
    align   = 1'b0;
    retrain = 1'b0;
    push(0, 1, 1, 0, 0, 0, -1);
    #1 rst_n = 1'b0;

    // Bring-up
    repeat (3) @(negedge clk);
    r = cyc;
    push(1, 0, 1, 0, 0, 0, r + 10);
    push(2, 0, 0, 0, 0, 0, r + 23);
    push(3, 0, 0, 0, 0, 0, r + 43);
    push(4, 0, 0, 1, 0, 0, r + 1067);
    rst_n = 1'b1;
    wait_to(r + 20);
    tx_done = 1'b1;
    wait_to(r + 40);
    align = 1'b1;
    wait_to(r + 1070);

    // Link loss from ST_UP, realign during re-sequence
    a = cyc;
    push(0, 1, 1, 0, 0, 1, a + 3);
    push(1, 0, 1, 0, 0, 1, a + 13);
    push(2, 0, 0, 0, 0, 1, a + 14);
    push(3, 0, 0, 0, 0, 1, a + 23);
    push(4, 0, 0, 1, 0, 0, a + 1047);
    align = 1'b0;
    wait_to(a + 20);
    align = 1'b1;
`ifdef GT_LINK_CTRL_STATS_EN
    check("linkdown_after_loss", 32'(linkdown_cnt), 32'd1);
`endif
    wait_to(a + 1050);

    // Retrain from ST_UP, then 1-cycle align glitch at stable count 500
    b = cyc;
    g = b + 511;
    push(0, 1, 1, 0, 0, 0, b + 1);
    push(1, 0, 1, 0, 0, 0, b + 11);
    push(2, 0, 0, 0, 0, 0, b + 12);
    push(3, 0, 0, 0, 0, 0, b + 13);
    push(0, 1, 1, 0, 0, 1, g + 3);
    push(1, 0, 1, 0, 0, 1, g + 13);
    push(2, 0, 0, 0, 0, 1, g + 14);
    push(3, 0, 0, 0, 0, 1, g + 15);
    push(4, 0, 0, 1, 0, 0, g + 1039);
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    wait_to(g);
    align = 1'b0;
    @(negedge clk);
    align = 1'b1;
    wait_to(g + 1045);
`ifdef GT_LINK_CTRL_STATS_EN
    check("linkdown_not_on_retrain_or_stable", 32'(linkdown_cnt), 32'd1);
`endif

    // Align never returns: three align timeouts then fault
    c = cyc;
    push(0, 1, 1, 0, 0, 0, c + 1);
    push(1, 0, 1, 0, 0, 0, c + 11);
    push(2, 0, 0, 0, 0, 0, c + 12);
    push(0, 1, 1, 0, 0, 1, c + 112);
    push(1, 0, 1, 0, 0, 1, c + 122);
    push(2, 0, 0, 0, 0, 1, c + 123);
    push(0, 1, 1, 0, 0, 2, c + 223);
    push(1, 0, 1, 0, 0, 2, c + 233);
    push(2, 0, 0, 0, 0, 2, c + 234);
    push(5, 1, 1, 0, 1, 3, c + 334);
    align   = 1'b0;
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    wait_to(c + 354);

    // Retrain out of ST_FAULT, normal bring-up follows
    d = cyc;
    push(0, 1, 1, 0, 0, 0, d + 1);
    push(1, 0, 1, 0, 0, 0, d + 11);
    push(2, 0, 0, 0, 0, 0, d + 12);
    push(3, 0, 0, 0, 0, 0, d + 13);
    push(4, 0, 0, 1, 0, 0, d + 1037);
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    align   = 1'b1;
    wait_to(d + 1040);

    // Asynchronous reset while in ST_UP
    e = cyc;
    push(0, 1, 1, 0, 0, 0, e + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outv), 32'(mk(0, 1, 1, 0, 0, 0)));
`ifdef GT_LINK_CTRL_STATS_EN
    check("linkdown_reset", 32'(linkdown_cnt), 32'd0);
`endif
    wait_to(e + 3);
    f = cyc;
    push(1, 0, 1, 0, 0, 0, f + 10);
    push(2, 0, 0, 0, 0, 0, f + 11);
    push(3, 0, 0, 0, 0, 0, f + 12);
    push(4, 0, 0, 1, 0, 0, f + 1036);
    rst_n = 1'b1;
    wait_to(f + 1045);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
